// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - single-outstanding load/store front end for the memory controller
// Optional misalignment trap: define LSU_MISALIGN_CHECK_EN.
module lsu_mem_adapter #(
  parameter int LAT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_wen_q, mem_wen_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        misaligned;
  logic [3:0]  mask_base;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;

  assign accept = req_valid && req_ready_q;

  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_size == 2'd1)
      misaligned = req_addr[0];
    else if (req_size[1])
      misaligned = (req_addr[1:0] != 2'b00);
`endif
  end

  always_comb begin
    case (req_size)
      2'd0:    mask_base = 4'b0001;
      2'd1:    mask_base = 4'b0011;
      default: mask_base = 4'b1111;
    endcase
  end

  // Lanes shifted past byte 3 simply fall off, which is the misaligned-without-trap behaviour.
  always_comb begin
    load_shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & load_shifted[7]}}, load_shifted[7:0]};
      2'd1:    load_ext = {{16{~uns_q & load_shifted[15]}}, load_shifted[15:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    mem_valid_d  = 1'b0;
    mem_wen_d    = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d      = req_addr[31:2];
          off_d       = req_addr[1:0];
          size_d      = req_size;
          uns_d       = req_unsigned;
          wen_d       = req_wen;
          wdata_d     = req_wdata << {req_addr[1:0], 3'b000};
          wmask_d     = mask_base << req_addr[1:0];
          req_ready_d = 1'b0;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_err_d   = 1'b1;
          end else if (LAT == 0) begin
            state_d     = S_ACC;
            mem_valid_d = 1'b1;
            mem_wen_d   = req_wen;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_ACC;
          mem_valid_d = 1'b1;
          mem_wen_d   = wen_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACC: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = wen_q ? 32'd0 : load_ext;
        resp_err_d   = 1'b0;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      addr_q       <= 30'd0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      wmask_q      <= 4'd0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_valid  = mem_valid_q;
  assign mem_wen    = mem_wen_q;
  assign mem_raddr  = {addr_q, 2'b00};
  assign mem_waddr  = {addr_q, 2'b00};
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = {4'b0000, wmask_q};

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// tb/tb_lsu_mem_adapter.sv - bench for lsu_mem_adapter at LAT=0 and LAT=3 against a byte-level model
module tb_lsu_mem_adapter;

  logic        clock = 1'b0;
  logic        reset [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic        mem_valid [2];
  logic [31:0] mem_raddr [2];
  logic [31:0] mem_waddr [2];
  logic        mem_wen [2];
  logic [31:0] mem_wdata [2];
  logic [7:0]  mem_wmask [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] tb_mem [2][16];
  logic [7:0]  model_mem [2][64];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lsu_mem_adapter #(.LAT(g == 0 ? 0 : 3)) u_dut (
      .clock        (clock),
      .reset        (reset[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_wen      (req_wen[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .resp_valid   (resp_valid[g]),
      .resp_ready   (resp_ready[g]),
      .resp_rdata   (resp_rdata[g]),
      .resp_err     (resp_err[g]),
      .mem_valid    (mem_valid[g]),
      .mem_raddr    (mem_raddr[g]),
      .mem_waddr    (mem_waddr[g]),
      .mem_wen      (mem_wen[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_wmask    (mem_wmask[g]),
      .mem_rdata    (mem_rdata[g])
    );
  end

  // Memory controller stand-in: combinational read, masked write on the strobe edge.
  always_comb begin
    for (int g = 0; g < 2; g++)
      mem_rdata[g] = mem_valid[g] ? tb_mem[g][mem_raddr[g][5:2]] : 32'hDEAD_BEEF;
  end

  always @(posedge clock) begin
    for (int g = 0; g < 2; g++)
      if (mem_valid[g] && mem_wen[g])
        for (int b = 0; b < 4; b++)
          if (mem_wmask[g][b]) tb_mem[g][mem_waddr[g][5:2]][8*b +: 8] = mem_wdata[g][8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] sz);
`ifdef LSU_MISALIGN_CHECK_EN
    return (int'(addr[1:0]) % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_word(input int d, input int idx, input logic [31:0] val);
    tb_mem[d][idx] = val;
    for (int b = 0; b < 4; b++) model_mem[d][idx*4 + b] = val[8*b +: 8];
  endtask

  task automatic txn(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [1:0] size, input logic uns, input int hold,
                     output logic [31:0] o_rdata, output logic [7:0] o_wmask, output logic [31:0] o_wdata);
    int n, off, widx, k, acc_k, resp_k, nvalid, nwen;
    bit mis;
    logic [31:0] exp_rdata, exp_wdata, obs_raddr, obs_waddr;
    logic [7:0] exp_mask;
    logic obs_wen;
    n = nbytes(size); off = int'(addr[1:0]); widx = int'(addr[5:2]); mis = is_mis(addr, size);
    exp_rdata = 32'd0; exp_wdata = 32'd0; exp_mask = 8'd0;
    acc_k = -1; resp_k = -1; nvalid = 0; nwen = 0;
    obs_raddr = 32'd0; obs_waddr = 32'd0; obs_wen = 1'b0; o_wmask = 8'd0; o_wdata = 32'd0;
    for (int l = off; l < 4; l++) exp_wdata[8*l +: 8] = wdata[8*(l-off) +: 8];
    for (int i = 0; i < n; i++) begin
      if (off + i < 4) begin
        exp_mask[off+i] = 1'b1;
        if (!mis && wen) model_mem[d][widx*4 + off + i] = wdata[8*i +: 8];
        else if (!wen) exp_rdata[8*i +: 8] = model_mem[d][widx*4 + off + i];
      end
    end
    if (!wen && !uns && n < 4 && exp_rdata[8*n-1]) exp_rdata = exp_rdata | ~((32'd1 << (8*n)) - 32'd1);
    if (mis || wen) exp_rdata = 32'd0;

    chk("req_ready_before", req_ready[d], 1'b1);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr; req_wdata[d] = wdata;
    req_size[d] = size; req_unsigned[d] = uns;
    step();
    req_valid[d] = 1'b0; req_wen[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
    req_size[d] = 2'($urandom); req_unsigned[d] = 1'($urandom);
    k = 1;
    while (resp_k < 0 && k <= 40) begin
      if (mem_valid[d]) begin
        nvalid++; acc_k = k; obs_raddr = mem_raddr[d]; obs_waddr = mem_waddr[d];
        obs_wen = mem_wen[d]; o_wmask = mem_wmask[d]; o_wdata = mem_wdata[d];
      end
      if (mem_wen[d]) nwen++;
      if (resp_valid[d]) resp_k = k;
      else begin step(); k++; end
    end
    chk("resp_latency", 32'(resp_k), mis ? 32'd1 : 32'(2 + lat_of(d)));
    chk("mem_valid_count", 32'(nvalid), mis ? 32'd0 : 32'd1);
    chk("mem_wen_count", 32'(nwen), (!mis && wen) ? 32'd1 : 32'd0);
    if (!mis) begin
      chk("acc_cycle", 32'(acc_k), 32'(1 + lat_of(d)));
      chk("mem_raddr", obs_raddr, {addr[31:2], 2'b00});
      chk("mem_waddr", obs_waddr, {addr[31:2], 2'b00});
      chk("mem_wen", obs_wen, wen);
      chk("mem_wmask", o_wmask, exp_mask);
      chk("mem_wdata", o_wdata, exp_wdata);
    end
    chk("resp_err", resp_err[d], mis);
    chk("resp_rdata", resp_rdata[d], exp_rdata);
    o_rdata = resp_rdata[d];
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_resp_valid", resp_valid[d], 1'b1);
      chk("hold_resp_rdata", resp_rdata[d], exp_rdata);
      chk("hold_req_ready", req_ready[d], 1'b0);
      chk("hold_mem_valid", mem_valid[d], 1'b0);
    end
    if (!mis) chk("mem_raddr_held", mem_raddr[d], {addr[31:2], 2'b00});
    resp_ready[d] = 1'b1;
    step();
    resp_ready[d] = 1'b0;
    chk("post_hs_req_ready", req_ready[d], 1'b1);
    chk("post_hs_resp_valid", resp_valid[d], 1'b0);
  endtask

  initial begin
    logic [31:0] r, wd;
    logic [7:0] wm;
    int cnt;
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_size[d] = 2'd0; req_unsigned[d] = 1'b0; resp_ready[d] = 1'b0;
      for (int i = 0; i < 16; i++) set_word(d, i, $urandom);
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) reset[d] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", req_ready[d], 1'b1);
      chk("rst_resp_valid", resp_valid[d], 1'b0);
      chk("rst_resp_rdata", resp_rdata[d], 32'd0);
      chk("rst_resp_err", resp_err[d], 1'b0);
      chk("rst_mem_valid", mem_valid[d], 1'b0);
      chk("rst_mem_wen", mem_wen[d], 1'b0);
      chk("rst_mem_wmask", mem_wmask[d], 8'd0);
      chk("rst_mem_wdata", mem_wdata[d], 32'd0);
      chk("rst_mem_raddr", mem_raddr[d], 32'd0);
      chk("rst_mem_waddr", mem_waddr[d], 32'd0);
    end

    set_word(0, 0, 32'h80FF_1234);
    txn(0, 1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b0, 0, r, wm, wd);
    chk("tp_signed_byte", r, 32'hFFFF_FF80);

    txn(1, 1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 0, r, wm, wd);
    chk("tp_store_half_mask", wm, 8'h0C);
    chk("tp_store_half_data", wd, 32'hBEEF_0000);

    set_word(0, 4, 32'hCAFE_F00D);
    txn(0, 1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0, 5, r, wm, wd);
    chk("tp_word_hold", r, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_CHECK_EN
    txn(0, 1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0, 0, r, wm, wd);
    chk("tp_mis_rdata", r, 32'd0);
`else
    txn(0, 1'b1, 32'h8000_0001, 32'h1234_5678, 2'd2, 1'b0, 0, r, wm, wd);
    chk("tp_mis_mask", wm, 8'h0E);
`endif

    set_word(1, 0, 32'h9ABC_0000);
    txn(1, 1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b1, 0, r, wm, wd);
    chk("tp_unsigned_half", r, 32'h0000_9ABC);

    // Reset while waiting: the access must be abandoned.
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
    req_wdata[1] = 32'h5555_AAAA; req_size[1] = 2'd2;
    step();
    req_valid[1] = 1'b0;
    step();
    reset[1] = 1'b1;
    step();
    reset[1] = 1'b0;
    chk("rst_wait_req_ready", req_ready[1], 1'b1);
    chk("rst_wait_resp_valid", resp_valid[1], 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_valid[1]) cnt++;
      step();
    end
    chk("rst_wait_no_access", 32'(cnt), 32'd0);

    // Reset during the access cycle: the store still lands, the response is dropped.
    req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 32'h8000_0024;
    req_wdata[0] = 32'h1122_3344; req_size[0] = 2'd2;
    step();
    req_valid[0] = 1'b0;
    chk("rst_acc_mem_valid", mem_valid[0], 1'b1);
    reset[0] = 1'b1;
    step();
    reset[0] = 1'b0;
    for (int b = 0; b < 4; b++) model_mem[0][9*4 + b] = 8'(32'h1122_3344 >> (8*b));
    chk("rst_acc_req_ready", req_ready[0], 1'b1);
    chk("rst_acc_resp_valid", resp_valid[0], 1'b0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_valid[0]) cnt++;
      step();
    end
    chk("rst_acc_no_repeat", 32'(cnt), 32'd0);
    txn(0, 1'b0, 32'h8000_0024, 32'd0, 2'd2, 1'b0, 0, r, wm, wd);
    chk("rst_acc_store_landed", r, 32'h1122_3344);

    for (int t = 0; t < 150; t++) begin
      txn(int'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom, 2'($urandom),
          1'($urandom), int'($urandom_range(0, 3)), r, wm, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
